// File: rtl/rs232_pkg.sv
// rtl/rs232_pkg.sv - shared constants, state encoding and baud helper for the RS232 receiver
package rs232_pkg;

  localparam int DATA_BITS = 8;
  localparam int STOP_BITS = 1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } rx_state_t;

  // Clock cycles per serial bit, rounded to the nearest integer.
  function automatic int baud_count(input real clock_freq, input real baud_rate);
    return int'(clock_freq / baud_rate);
  endfunction

endpackage

// File: rtl/axis_fifo.sv
// rtl/axis_fifo.sv - first-word-fall-through stream FIFO
// Ports:
//   clock, reset          rising-edge clock, synchronous active-high reset
//   idata/ivalid/iready   write side; a write happens when ivalid && iready
//   odata/ovalid/oready   read side; odata shows the head entry while ovalid=1
//   count                 current occupancy (0..DEPTH)
module axis_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [WIDTH-1:0]         idata,
  input  logic                     ivalid,
  output logic                     iready,
  output logic [WIDTH-1:0]         odata,
  output logic                     ovalid,
  input  logic                     oready,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push;
  logic             pop;

  assign iready = (count != (AW+1)'(DEPTH));
  assign ovalid = (count != '0);
  // Gate the head so odata reads 0 whenever nothing is valid (including reset).
  assign odata  = ovalid ? mem[rd_ptr] : '0;
  assign push   = ivalid && iready;
  assign pop    = ovalid && oready;

  always_ff @(posedge clock) begin
    if (push) begin
      mem[wr_ptr] <= idata;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/rs232_to_axis.sv
// rtl/rs232_to_axis.sv - 8N1 RS232 receiver feeding a small stream FIFO with RTS flow control
// Ports:
//   clock, reset          rising-edge clock, synchronous active-high reset
//   rxd_pin               asynchronous serial input, idle high
//   rtsn_pin              active-low ready-to-send towards the sender's CTSn
//   odata/ovalid/oready   received byte stream
//   framing_error         one-cycle pulse when the stop bit is sampled low
//   overrun               one-cycle pulse when a byte completes with the FIFO full
module rs232_to_axis
  import rs232_pkg::*;
#(
  parameter real CLOCK_FREQ = 133000000.0,
  parameter real BAUD_RATE  = 115200.0,
  parameter int  FIFO_DEPTH = 4,
  parameter int  RTS_SLACK  = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       rxd_pin,
  output logic       rtsn_pin,
  output logic [7:0] odata,
  output logic       ovalid,
  input  logic       oready,
  output logic       framing_error,
  output logic       overrun
);

  localparam int BAUD_COUNT = baud_count(CLOCK_FREQ, BAUD_RATE);
  localparam int HALF_COUNT = BAUD_COUNT / 2;
  localparam int CNT_W      = (BAUD_COUNT > 2) ? $clog2(BAUD_COUNT) : 1;
  localparam int OCC_W      = $clog2(FIFO_DEPTH) + 1;
  localparam int IDX_W      = $clog2(DATA_BITS);

  localparam logic [CNT_W-1:0] BAUD_RELOAD = CNT_W'(BAUD_COUNT - 1);
  localparam logic [CNT_W-1:0] HALF_RELOAD = CNT_W'(HALF_COUNT - 1);
  localparam logic [OCC_W-1:0] RTS_LEVEL   = OCC_W'(FIFO_DEPTH - RTS_SLACK);
  localparam logic [IDX_W-1:0] LAST_BIT    = IDX_W'(DATA_BITS - 1);

  logic                 rxd_pin2;
  logic                 rxd;
  logic                 rxd_prev;
  rx_state_t            state;
  logic [CNT_W-1:0]     cnt;
  logic [IDX_W-1:0]     bit_idx;
  logic [DATA_BITS-1:0] shift;
  logic                 expire;
  logic                 fifo_wr;
  logic                 fifo_iready;
  logic [OCC_W-1:0]     fifo_count;

  assign expire  = (cnt == '0);
  // The byte is committed on the very edge that samples a good stop bit.
  assign fifo_wr = (state == STOP) && expire && rxd && fifo_iready;

  // Two-flop synchronizer, plus one more stage for falling-edge detection.
  always_ff @(posedge clock) begin
    if (reset) begin
      rxd_pin2 <= 1'b1;
      rxd      <= 1'b1;
      rxd_prev <= 1'b1;
    end else begin
      rxd_pin2 <= rxd_pin;
      rxd      <= rxd_pin2;
      rxd_prev <= rxd;
    end
  end

  // Deassert RTS early enough that a byte already in flight still fits.
  always_ff @(posedge clock) begin
    if (reset) begin
      rtsn_pin <= 1'b1;
    end else begin
      rtsn_pin <= (fifo_count >= RTS_LEVEL);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= IDLE;
      cnt           <= '0;
      bit_idx       <= '0;
      shift         <= '0;
      framing_error <= 1'b0;
      overrun       <= 1'b0;
    end else begin
      framing_error <= 1'b0;
      overrun       <= 1'b0;
      if (!expire) cnt <= cnt - 1'b1;
      case (state)
        IDLE: begin
          if (!rxd && rxd_prev) begin
            cnt   <= HALF_RELOAD;
            state <= START;
          end
        end
        START: begin
          if (expire) begin
            if (!rxd) begin
              cnt     <= BAUD_RELOAD;
              bit_idx <= '0;
              state   <= DATA;
            end else begin
              state <= IDLE;
            end
          end
        end
        DATA: begin
          if (expire) begin
            shift   <= {rxd, shift[DATA_BITS-1:1]};
            cnt     <= BAUD_RELOAD;
            bit_idx <= bit_idx + 1'b1;
            if (bit_idx == LAST_BIT) state <= STOP;
          end
        end
        STOP: begin
          if (expire) begin
            if (rxd) begin
              if (!fifo_iready) overrun <= 1'b1;
              state <= IDLE;
            end else begin
              framing_error <= 1'b1;
              state         <= BREAK;
            end
          end
        end
        BREAK: begin
          if (rxd) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  axis_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock  (clock),
    .reset  (reset),
    .idata  (shift),
    .ivalid (fifo_wr),
    .iready (fifo_iready),
    .odata  (odata),
    .ovalid (ovalid),
    .oready (oready),
    .count  (fifo_count)
  );

endmodule

// File: tb/tb_rs232_to_axis.sv
// tb/tb_rs232_to_axis.sv - self-checking bench for rs232_to_axis
module tb_rs232_to_axis;

  localparam int BIT = 16;

  logic       clock = 1'b0;
  logic       reset;
  logic       rxd_pin;
  logic       rtsn_pin;
  logic [7:0] odata;
  logic       ovalid;
  logic       oready;
  logic       framing_error;
  logic       overrun;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [7:0] rx_q[$];
  int         rx_t[$];
  int         fe_cnt, ov_cnt, ov_t, rts_rise_t, valid_cnt;

  rs232_to_axis #(
    .CLOCK_FREQ (1600000.0),
    .BAUD_RATE  (100000.0),
    .FIFO_DEPTH (4),
    .RTS_SLACK  (2)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .rxd_pin       (rxd_pin),
    .rtsn_pin      (rtsn_pin),
    .odata         (odata),
    .ovalid        (ovalid),
    .oready        (oready),
    .framing_error (framing_error),
    .overrun       (overrun)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc++;

  // Records observed behaviour on the falling edge; all judgement is in the initial block.
  always @(negedge clock) begin
    if (!reset) begin
      if (ovalid) valid_cnt++;
      if (ovalid && oready) begin
        rx_q.push_back(odata);
        rx_t.push_back(cyc);
      end
      if (framing_error) fe_cnt++;
      if (overrun) begin
        ov_cnt++;
        ov_t = cyc;
      end
      if (rtsn_pin && rts_rise_t < 0) rts_rise_t = cyc;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_log();
    rx_q.delete();
    rx_t.delete();
    fe_cnt = 0; ov_cnt = 0; ov_t = -1; rts_rise_t = -1; valid_cnt = 0;
  endtask

  // Called and returns at posedge+1 so every drive is away from the clock edge.
  task automatic drive(input logic v, input int n);
    rxd_pin = v;
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    drive(1'b0, BIT);
    for (int i = 0; i < 8; i++) drive(b[i], BIT);
    drive(stop_bit, BIT);
  endtask

  task automatic check_bytes(input string tag, input logic [7:0] exp_q[$]);
    check({tag, "_count"}, rx_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      check({tag, "_byte"}, (i < rx_q.size()) ? {24'h0, rx_q[i]} : 32'hDEAD, {24'h0, exp_q[i]});
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rtsn"}, rtsn_pin, 1'b1);
    check({tag, "_ovalid"}, ovalid, 1'b0);
    check({tag, "_odata"}, odata, 8'h00);
    check({tag, "_fe"}, framing_error, 1'b0);
    check({tag, "_ov"}, overrun, 1'b0);
  endtask

  initial begin
    logic [7:0] exp_q[$];
    logic [7:0] b;
    int t0, base, gap, d;
    bit done;

    reset = 1'b1; rxd_pin = 1'b1; oready = 1'b1;
    clear_log();
    repeat (3) @(posedge clock);
    #1;
    check_reset_outputs("reset");
    reset = 1'b0;
    @(posedge clock); #1;
    check("rtsn_after_reset", rtsn_pin, 1'b0);
    drive(1'b1, 20);

    // Single frame latency and cleanliness.
    clear_log();
    t0 = cyc;
    send_frame(8'hA5, 1'b1);
    drive(1'b1, 40);
    exp_q = '{8'hA5};
    check_bytes("a5", exp_q);
    d = (rx_t.size() > 0) ? rx_t[0] - t0 : -1000;
    check("a5_latency_window", (d >= 152 && d <= 156), 1'b1);
    check("a5_valid_cycles", valid_cnt, 1);
    check("a5_no_fe", fe_cnt, 0);
    check("a5_no_ov", ov_cnt, 0);
    check("a5_rts_stays_low", rts_rise_t, 32'hFFFF_FFFF);

    // Short low glitch is ignored, following frame still received.
    clear_log();
    drive(1'b0, 4);
    drive(1'b1, 40);
    check("glitch_no_byte", rx_q.size(), 0);
    check("glitch_no_fe", fe_cnt, 0);
    send_frame(8'h5A, 1'b1);
    drive(1'b1, 40);
    exp_q = '{8'h5A};
    check_bytes("after_glitch", exp_q);

    // Framing error followed by a long break yields exactly one pulse.
    clear_log();
    send_frame(8'h3C, 1'b0);
    drive(1'b0, 64);
    drive(1'b1, 40);
    send_frame(8'h81, 1'b1);
    drive(1'b1, 40);
    check("break_fe_once", fe_cnt, 1);
    exp_q = '{8'h81};
    check_bytes("after_break", exp_q);

    // Fill the FIFO with the consumer stalled.
    clear_log();
    oready = 1'b0;
    base = cyc;
    for (int k = 1; k <= 5; k++) send_frame(8'(k), 1'b1);
    drive(1'b1, 40);
    d = rts_rise_t - (base + BIT*10 + 156);
    check("fill_rts_rise_window", (rts_rise_t >= 0 && d >= -2 && d <= 2), 1'b1);
    check("fill_ov_once", ov_cnt, 1);
    d = ov_t - (base + BIT*10*4 + 155);
    check("fill_ov_window", (ov_t >= 0 && d >= -2 && d <= 2), 1'b1);
    check("fill_held_rts", rtsn_pin, 1'b1);
    check("fill_head_stable", odata, 8'h01);
    oready = 1'b1;
    drive(1'b1, 10);
    exp_q = '{8'h01, 8'h02, 8'h03, 8'h04};
    check_bytes("drain", exp_q);
    for (int i = 1; i < rx_t.size(); i++)
      check("drain_consecutive", rx_t[i] - rx_t[i-1], 1);
    check("drain_rts_low", rtsn_pin, 1'b0);

    // Toggling oready while frames stream continuously.
    clear_log();
    done = 1'b0;
    exp_q.delete();
    fork
      begin
        for (int k = 0; k < 16; k++) begin
          send_frame(8'h10 + 8'(k), 1'b1);
          exp_q.push_back(8'h10 + 8'(k));
        end
        drive(1'b1, 40);
        done = 1'b1;
      end
      begin
        while (!done) begin
          oready = ~oready;
          @(posedge clock); #1;
        end
      end
    join
    oready = 1'b1;
    drive(1'b1, 10);
    check_bytes("toggle", exp_q);
    check("toggle_no_ov", ov_cnt, 0);

    // Random bytes, random gaps, random consumer stalls.
    clear_log();
    done = 1'b0;
    exp_q.delete();
    fork
      begin
        for (int k = 0; k < 8; k++) begin
          b = 8'($urandom);
          gap = $urandom_range(0, 20);
          if (gap > 0) drive(1'b1, gap);
          send_frame(b, 1'b1);
          exp_q.push_back(b);
        end
        drive(1'b1, 40);
        done = 1'b1;
      end
      begin
        while (!done) begin
          oready = 1'($urandom);
          @(posedge clock); #1;
        end
      end
    join
    oready = 1'b1;
    drive(1'b1, 10);
    check_bytes("random", exp_q);
    check("random_no_ov", ov_cnt, 0);
    check("random_no_fe", fe_cnt, 0);

    // Reset in the middle of a frame while a byte sits in the FIFO.
    oready = 1'b0;
    send_frame(8'h77, 1'b1);
    drive(1'b1, 20);
    check("pre_reset_ovalid", ovalid, 1'b1);
    check("pre_reset_odata", odata, 8'h77);
    clear_log();
    drive(1'b0, BIT);
    for (int i = 0; i < 4; i++) drive(1'b1, BIT);
    drive(1'b1, BIT/2);
    reset = 1'b1;
    @(posedge clock); #1;
    check_reset_outputs("mid_reset");
    reset = 1'b0;
    @(posedge clock); #1;
    check("mid_reset_rtsn_release", rtsn_pin, 1'b0);
    check("mid_reset_flushed", ovalid, 1'b0);
    oready = 1'b1;
    drive(1'b1, BIT*5);
    send_frame(8'h42, 1'b1);
    drive(1'b1, 40);
    exp_q = '{8'h42};
    check_bytes("after_reset", exp_q);
    check("after_reset_no_fe", fe_cnt, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
